// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the uart_tx request scheduler.
// The optional WAIT_DONE watchdog is enabled with UART_TX_SCHED_TIMEOUT_EN.
package uart_pkg;

  localparam int BIT_DURATION       = 14;
  localparam int FRAME_BITS         = 11;
  localparam int FRAME_CYCLES       = BIT_DURATION * FRAME_BITS;
  localparam int DEF_SETTLE_CYCLES  = 160;
  localparam int DEF_TIMEOUT_CYCLES = 200;

  typedef enum logic [2:0] {
    SETTLE,
    IDLE,
    LAUNCH,
    WAIT_DONE,
    ACK
  } sched_state_e;

  // Byte and parity type latched for the frame in flight.
  typedef struct packed {
    logic [7:0] data;
    logic       parity;
  } frame_t;

  // One counter serves both the settle delay and the watchdog.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 2) ? $clog2(m) : 1;
  endfunction

  localparam int CNT_W_DEF = cnt_width(DEF_SETTLE_CYCLES, DEF_TIMEOUT_CYCLES);

endpackage

// File: rtl/uart_tx_sched_arb.sv
// Combinational round-robin pick: first set request searching upward
// from (last+1) mod NUM_REQ, with wrap.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    last_i,
  output logic [NUM_REQ-1:0] gnt_oh_o,
  output logic [ID_W-1:0]    gnt_idx_o,
  output logic               gnt_vld_o
);

  always_comb begin
    logic            found;
    int              p;
    logic [ID_W-1:0] sel;
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    p         = 0;
    sel       = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      p = int'(last_i) + off;
      if (p >= NUM_REQ) p = p - NUM_REQ;
      sel = ID_W'(p);
      if (!found && req_i[sel]) begin
        found         = 1'b1;
        gnt_idx_o     = sel;
        gnt_oh_o[sel] = 1'b1;
      end
    end
  end

  assign gnt_vld_o = |req_i;

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx between NUM_REQ byte requesters.
// Define UART_TX_SCHED_TIMEOUT_EN to build the WAIT_DONE watchdog.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = $clog2(NUM_REQ),
  parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                 clk_3125,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_parity,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  output logic                 tx_parity_type,
  input  logic                 tx_done,
  output logic                 busy,
  output logic [ID_W-1:0]      grant_id,
  output logic                 err_timeout
);

  localparam int              CNT_W       = cnt_width(SETTLE_CYCLES, TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  sched_state_e             state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  frame_t                   frame_q, frame_d, pick_frame;
  logic [ID_W-1:0]          gid_q, gid_d, last_q, last_d;
  logic [NUM_REQ-1:0][7:0]  req_bytes;
  logic [NUM_REQ-1:0]       pick_oh;
  logic [ID_W-1:0]          pick_idx;
  logic                     pick_vld;

  assign req_bytes = req_data;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) u_arb (
    .req_i    (req_valid),
    .last_i   (last_q),
    .gnt_oh_o (pick_oh),
    .gnt_idx_o(pick_idx),
    .gnt_vld_o(pick_vld)
  );

  always_comb begin
    pick_frame = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_oh[i]) begin
        pick_frame.data   = pick_frame.data | req_bytes[i];
        pick_frame.parity = pick_frame.parity | req_parity[i];
      end
    end
  end

`ifdef UART_TX_SCHED_TIMEOUT_EN
  logic timeout_hit;
  assign timeout_hit = (state_q == WAIT_DONE) && !tx_done &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge clk_3125) begin
    if (rst) state_q <= SETTLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk_3125) begin
    if (rst) begin
      cnt_q   <= '0;
      frame_q <= '0;
      gid_q   <= '0;
      last_q  <= ID_W'(NUM_REQ - 1);
    end else begin
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      gid_q   <= gid_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    gid_d   = gid_q;
    last_d  = last_q;
    unique case (state_q)
      SETTLE: begin
        // uart_tx has no reset, so wait out any frame it may be emitting.
        if (cnt_q == SETTLE_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE: begin
        if (pick_vld) begin
          state_d = LAUNCH;
          frame_d = pick_frame;
          gid_d   = pick_idx;
        end
      end
      LAUNCH: begin
        state_d = WAIT_DONE;
        cnt_d   = '0;
      end
      WAIT_DONE: begin
        if (tx_done) begin
          state_d = ACK;
          last_d  = gid_q;
        end
`ifdef UART_TX_SCHED_TIMEOUT_EN
        else if (timeout_hit) begin
          // Requester keeps its request and is retried after settling.
          state_d = SETTLE;
          cnt_d   = '0;
          last_d  = gid_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ACK:     state_d = IDLE;
      default: state_d = SETTLE;
    endcase
  end

  always_comb begin
    tx_start = (state_q == LAUNCH);
    busy     = (state_q == LAUNCH) || (state_q == WAIT_DONE);
    req_ack  = '0;
    if (state_q == ACK) req_ack[gid_q] = 1'b1;
`ifdef UART_TX_SCHED_TIMEOUT_EN
    err_timeout = timeout_hit;
`else
    err_timeout = 1'b0;
`endif
  end

  assign tx_data        = frame_q.data;
  assign tx_parity_type = frame_q.parity;
  assign grant_id       = gid_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: directed vector table, reset and
// tx_done corner sequences, then randomized frames against a round-robin model.
module tb_uart_tx_sched;

  localparam int N = 4;

  logic           clk_3125 = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_parity = '0;
  logic           tx_done = 1'b0;
  logic [N-1:0]   req_ack;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_parity_type;
  logic           busy;
  logic [1:0]     grant_id;
  logic           err_timeout;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;
  int model_last = N - 1;

  uart_tx_sched #(.NUM_REQ(N)) dut (
    .clk_3125      (clk_3125),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_parity    (req_parity),
    .req_ack       (req_ack),
    .tx_start      (tx_start),
    .tx_data       (tx_data),
    .tx_parity_type(tx_parity_type),
    .tx_done       (tx_done),
    .busy          (busy),
    .grant_id      (grant_id),
    .err_timeout   (err_timeout)
  );

  always #160 clk_3125 = ~clk_3125;

  always @(negedge clk_3125) if (err_timeout === 1'b1) err_pulses++;

  initial begin
    #(320 * 90000);
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [3:0] mask;
    logic [7:0] base;
    logic [3:0] par;
    int         gid;
    logic [7:0] data;
    bit         epar;
    bit         mut;
    bit         ld;
    bit         inj;
  } vec_t;

  vec_t tbl[12];

  task automatic tick();
    @(posedge clk_3125);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic set_reqs(input logic [3:0] mask, input logic [7:0] base, input logic [3:0] par);
    req_valid  = mask;
    req_parity = par;
    for (int i = 0; i < N; i++) req_data[8*i +: 8] = base + 8'(i);
  endtask

  // Round-robin reference: first valid requester after the last served one.
  function automatic int rr_pick(input logic [3:0] mask, input int last);
    for (int off = 1; off <= N; off++) begin
      if (mask[(last + off) % N]) return (last + off) % N;
    end
    return -1;
  endfunction

  task automatic wait_start(input int exp_wait, input bit inj);
    int w;
    bit quiet;
    w = 0;
    quiet = 1'b1;
    while (tx_start !== 1'b1 && w < 400) begin
      tx_done = inj && (w % 3 == 1);
      tick();
      w++;
      if (req_ack !== '0) quiet = 1'b0;
    end
    tx_done = 1'b0;
    chk("start_latency", w, exp_wait);
    chk("no_ack_before_start", quiet, 1);
  endtask

  task automatic run_frame(input int exp_gid, input logic [7:0] exp_data, input bit exp_par,
                           input int exp_wait, input int len, input bit mutate,
                           input bit launch_done, input bit inj);
    bit stable;
    stable = 1'b1;
    wait_start(exp_wait, inj);
    tx_done = launch_done;
    chk("grant_id", grant_id, exp_gid);
    chk("tx_data", tx_data, exp_data);
    chk("tx_parity_type", tx_parity_type, exp_par);
    chk("busy_launch", busy, 1);
    if (mutate) begin
      req_data[8*exp_gid +: 8] = ~exp_data;
      req_valid[exp_gid] = 1'b0;
    end
    for (int i = 0; i < len; i++) begin
      tick();
      tx_done = 1'b0;
      if (tx_start !== 1'b0 || tx_data !== exp_data || tx_parity_type !== exp_par ||
          busy !== 1'b1 || req_ack !== '0) stable = 1'b0;
    end
    chk("frame_hold", stable, 1);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("req_ack", req_ack, 32'(1) << exp_gid);
    chk("busy_ack", busy, 0);
  endtask

  initial begin
    int g;
    logic [3:0] m;
    tbl[0]  = '{4'b0001, 8'hA5, 4'b0000, 0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{4'b1111, 8'h10, 4'b0000, 1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{4'b1111, 8'h10, 4'b0100, 2, 8'h12, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{4'b1111, 8'h10, 4'b0000, 3, 8'h13, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{4'b1111, 8'h10, 4'b0000, 0, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{4'b1010, 8'h20, 4'b1000, 1, 8'h21, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{4'b1010, 8'h20, 4'b1000, 3, 8'h23, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{4'b0100, 8'h05, 4'b0100, 2, 8'h07, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{4'b1001, 8'h30, 4'b0001, 3, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{4'b1001, 8'h30, 4'b0001, 0, 8'h30, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{4'b0110, 8'hF0, 4'b0010, 1, 8'hF1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{4'b0110, 8'hF0, 4'b0010, 2, 8'hF2, 1'b0, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    tick();
    tick();
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_parity", tx_parity_type, 0);
    chk("rst_req_ack", req_ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_err", err_timeout, 0);
    rst = 1'b0;

    for (int k = 0; k < 12; k++) begin
      set_reqs(tbl[k].mask, tbl[k].base, tbl[k].par);
      run_frame(tbl[k].gid, tbl[k].data, tbl[k].epar, (k == 0) ? 161 : 2,
                6 + k, tbl[k].mut, tbl[k].ld, tbl[k].inj);
    end

    // Reset while a frame is in flight: no ack, full settle, then served again.
    set_reqs(4'b0010, 8'h5A, 4'b0010);
    wait_start(2, 1'b0);
    chk("pre_rst_grant", grant_id, 1);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    chk("rst_wait_start", tx_start, 0);
    chk("rst_wait_busy", busy, 0);
    chk("rst_wait_ack", req_ack, 0);
    chk("rst_wait_data", tx_data, 0);
    rst = 1'b0;
    run_frame(1, 8'h5B, 1'b1, 161, 10, 1'b0, 1'b0, 1'b1);
    model_last = 1;

    for (int f = 0; f < 40; f++) begin
      m = 4'($urandom_range(1, 15));
      req_valid  = m;
      req_parity = 4'($urandom);
      for (int i = 0; i < N; i++) req_data[8*i +: 8] = 8'($urandom);
      g = rr_pick(m, model_last);
      run_frame(g, req_data[8*g +: 8], req_parity[g], 2, $urandom_range(2, 25),
                1'($urandom), 1'($urandom), 1'($urandom));
      model_last = g;
    end

`ifdef UART_TX_SCHED_TIMEOUT_EN
    begin
      int k;
      bit q;
      set_reqs(4'b0001, 8'h3C, 4'b0001);
      wait_start(2, 1'b0);
      k = 0;
      q = 1'b1;
      while (err_timeout !== 1'b1 && k < 300) begin
        tick();
        k++;
        if (req_ack !== '0) q = 1'b0;
      end
      chk("timeout_cycle", k, 200);
      chk("timeout_no_ack", q, 1);
      tick();
      chk("timeout_busy", busy, 0);
      chk("timeout_ack", req_ack, 0);
      run_frame(0, 8'h3C, 1'b1, 161, 5, 1'b0, 1'b0, 1'b0);
    end
    chk("err_pulses", err_pulses, 1);
`else
    chk("err_pulses", err_pulses, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares one uart_tx transmitter between NUM_REQ byte requesters.
- Latches the winning requester's byte and parity type and pulses tx_start.
- Holds data stable for the whole frame, waits for tx_done, then acknowledges the requester.
- Sits between uart_tx and the producer blocks (command echo, status reporter, debug stream).

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ), width of grant_id.
- SETTLE_CYCLES, 160, idle cycles after reset before the first grant. Exceeds one full frame of 11 bits × 14 clocks, because uart_tx has no reset.
- TIMEOUT_CYCLES, 200, WAIT_DONE watchdog limit. Used only with UART_TX_SCHED_TIMEOUT_EN.

Ports:
- clk_3125  in  1  system clock, 3.125 MHz
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NUM_REQ  per-requester request, level
- req_data  in  8*NUM_REQ  byte for requester i at [8i+7:8i]
- req_parity  in  NUM_REQ  parity type per requester (1 = odd, 0 = even)
- req_ack  out  NUM_REQ  one-cycle pulse when requester i's frame has completed
- tx_start  out  1  to uart_tx, one-cycle pulse
- tx_data  out  8  to uart_tx data, registered, stable for the whole frame
- tx_parity_type  out  1  to uart_tx parity_type, registered
- tx_done  in  1  from uart_tx, one-cycle pulse at end of frame
- busy  out  1  high in LAUNCH and WAIT_DONE
- grant_id  out  ID_W  index of the current or last granted requester
- err_timeout  out  1  one-cycle pulse on watchdog expiry; tied 0 without the macro

Behaviour:
- Clock and reset: one clock, clk_3125. Reset rst is synchronous and active-high.
- Reset values:
  - State = SETTLE, settle counter = 0.
  - tx_start = 0, tx_data = 0, tx_parity_type = 0.
  - req_ack = 0, busy = 0, err_timeout = 0, grant_id = 0.
  - Round-robin pointer last = NUM_REQ-1, so requester 0 has first priority.
- SETTLE:
  - Count clocks; ignore requests and tx_done.
  - When the count reaches SETTLE_CYCLES-1, go to IDLE.
- IDLE:
  - If any req_valid is high, pick the first set index searching from (last+1) mod NUM_REQ upward with wrap.
  - Register its byte into tx_data and its parity into tx_parity_type; set grant_id; go to LAUNCH.
  - A tx_done seen in IDLE is ignored.
- LAUNCH:
  - tx_start = 1 for exactly this one cycle; go to WAIT_DONE.
  - Latency: req_valid sampled high in IDLE at cycle N gives tx_start high at cycle N+1.
- WAIT_DONE:
  - tx_start = 0; tx_data and tx_parity_type are held.
  - On tx_done: pulse req_ack[grant_id] on the next cycle, set last = grant_id, return to IDLE.
  - The earliest next grant is the cycle after the ack.
- Requester rules:
  - Hold req_valid and req_data until req_ack.
  - Deasserting req_valid before grant withdraws the request.
  - Deasserting after grant has no effect; the latched frame completes and is still acked.
- Requester sees its own ack: requester i must drop or update req_valid in the ack cycle. The arbiter samples in IDLE on the cycle after the ack.
- Simultaneous requests: exactly one grant per frame, rotating.
  - With all requesters valid, grant order is 0,1,2,3,0,...
  - No requester waits more than NUM_REQ-1 frames.
- Boundaries:
  - Single requester repeatedly valid: back-to-back frames, gap between tx_done and the next tx_start = 3 cycles (ack, IDLE, LAUNCH).
  - rst in any state returns to SETTLE on the next edge; no ack is issued for an in-flight frame.
  - tx_done arriving in SETTLE or LAUNCH is dropped.

Optional Feature:
- Macro: UART_TX_SCHED_TIMEOUT_EN.
- When defined:
  - A counter runs in WAIT_DONE.
  - If it reaches TIMEOUT_CYCLES-1 without tx_done: pulse err_timeout, issue no req_ack, set last = grant_id, go to SETTLE.
  - The requester keeps req_valid and is retried later.
- When undefined: no counter is built, err_timeout is tied 0, and WAIT_DONE waits indefinitely.

Decomposition:
- Package uart_pkg contains:
  - State enum {SETTLE, IDLE, LAUNCH, WAIT_DONE, ACK}.
  - Constants BIT_DURATION = 14, FRAME_BITS = 11, FRAME_CYCLES = 154.
  - Counter width constant sized for max(SETTLE_CYCLES, TIMEOUT_CYCLES).
- Sub-module rr_arbiter: combinational one-hot and index pick from a request vector and the last pointer, parameterised by NUM_REQ.

Test Plan:
- After rst, hold req_valid=4'b0001 with data 8'hA5 → no tx_start for 160 cycles, then tx_start pulse with tx_data=8'hA5, req_ack[0] one cycle after tx_done.
- req_valid=4'b1111 held continuously, data 8'h10..8'h13 → grants ordered 0,1,2,3,0; each tx_data matches; each ack goes to the matching requester.
- req_parity[2]=1 with data 8'h07 via a uart_tx instance → parity bit on tx line = 0 (odd parity, three ones); tx_parity_type=1 held for the whole frame.
- Change req_data[1] mid-frame after grant → tx_data unchanged until req_ack[1].
- Assert rst during WAIT_DONE → tx_start=0, no req_ack, 160-cycle settle, then the request is served normally.
- With UART_TX_SCHED_TIMEOUT_EN, tx_done stubbed low → err_timeout pulse at cycle 200 of WAIT_DONE, no ack, re-entry to SETTLE.
